// File: rtl/cache_bridge_pkg.sv
// cache_bridge_pkg
// Shared constants and helpers for the clocked cache-request bridge.
//   DEFAULT_DATA_W : default width of the bundled request word.
//   SYNC_STAGES    : depth of the i_drive synchronizer. It is 3 when the
//                    CACHE_BRIDGE_SYNC3_EN macro is defined, otherwise 2.
//   ptr_w / cnt_w  : FIFO pointer and occupancy-counter widths for a depth.
package cache_bridge_pkg;

    localparam int DEFAULT_DATA_W = 64;

`ifdef CACHE_BRIDGE_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Count must represent 0..depth inclusive, hence one extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cache_req_clk_bridge_sync_bit.sv
// sync_bit
// Single-bit multi-flop synchronizer with synchronous active-high reset to 0.
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input bit
//   q   : synchronized output (last stage)
// Parameter STAGES (>= 2) sets the number of flops in the chain.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cache_req_clk_bridge.sv
// cache_req_clk_bridge
// Receives the two-phase (transition-signalled) drive token and bundled
// request word from the upstream cache pipeline controller. It converts them
// into a valid/ready stream through a DEPTH-entry FIFO. The free token is
// returned upstream only when there is room for the next request.
// Ports:
//   clk        : sole clock
//   rst        : synchronous active-high reset
//   i_drive    : upstream token, each toggle is one request (async to clk)
//   o_free     : acknowledge, each toggle releases one token
//   i_data     : bundled request word, stable from i_drive toggle to o_free
//   o_valid    : head entry present (registered)
//   i_ready    : consumer accepts head; pop = o_valid & i_ready
//   o_data     : head entry
//   o_count    : current occupancy 0..DEPTH
//   o_overflow : sticky flag, upstream toggled while the FIFO was full
// Macro CACHE_BRIDGE_SYNC3_EN selects a 3-flop synchronizer (default is 2),
// through cache_bridge_pkg::SYNC_STAGES.
module cache_req_clk_bridge
    import cache_bridge_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_drive,
    output logic                    o_free,
    input  logic [DATA_W-1:0]       i_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [DATA_W-1:0]       o_data,
    output logic [cnt_w(DEPTH)-1:0] o_count,
    output logic                    o_overflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic              drv_s;
    logic              drv_prev;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              free_pending;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              token;
    logic              pop;
    logic              full;
    logic              push;
    logic              overflow_evt;
    logic [CW-1:0]     count_next;
    logic              free_toggle;
    logic              pending_next;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync_drive (
        .clk(clk),
        .rst(rst),
        .d  (i_drive),
        .q  (drv_s)
    );

    always_comb begin
        token        = drv_s ^ drv_prev;
        pop          = o_valid & i_ready;
        full         = (count == FULL_CNT);
        // A pop on the same edge frees a slot, so a token can still land.
        push         = token & (~full | pop);
        overflow_evt = token & full & ~pop;
        count_next   = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        // free_pending implies the FIFO was full. Push and pop at full leaves it
        // full: the pop releases the older held token and the new push holds
        // its own. In every case o_free toggles at most once per edge.
        free_toggle  = (push & (count_next != FULL_CNT)) | (pop & free_pending);
        pending_next = free_pending;
        if (push && (count_next == FULL_CNT)) begin
            pending_next = 1'b1;
        end else if (pop) begin
            pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drv_prev     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            free_pending <= 1'b0;
            o_free       <= 1'b0;
            o_valid      <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            drv_prev     <= drv_s;
            count        <= count_next;
            free_pending <= pending_next;
            o_valid      <= (count_next != '0);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (free_toggle) begin
                o_free <= ~o_free;
            end
            if (overflow_evt) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Storage is data only; contents survive reset and are simply unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    assign o_data  = mem[rd_ptr];
    assign o_count = count;

endmodule

// File: tb/tb_cache_req_clk_bridge.sv
module tb_cache_req_clk_bridge;
    import cache_bridge_pkg::*;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_drive;
    logic              o_free;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic [2:0]        o_count;
    logic              o_overflow;

    int n_tests = 0;
    int n_fail  = 0;
    logic exp_free;

    cache_req_clk_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_drive   (i_drive),
        .o_free    (o_free),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_count   (o_count),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_drive = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        tick();
        tick();
        rst      = 1'b0;
        exp_free = 1'b0;
    endtask

    // Toggle i_drive and advance to the edge where the token pushes.
    task automatic send_token(input logic [DATA_W-1:0] d);
        i_data  = d;
        i_drive = ~i_drive;
        repeat (SYNC_STAGES + 1) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
        n_tests++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", o_count); end
        n_tests++; if (o_free !== 1'b0) begin n_fail++; $display("FAIL reset_free got %b want 0", o_free); end
        n_tests++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", o_overflow); end
    endtask

    task automatic test_single_token();
        do_reset();
        i_data  = 64'hA5A5_0000_0000_0001;
        i_drive = 1'b1;
        repeat (SYNC_STAGES) tick();
        n_tests++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL single_early_count got %0d want 0", o_count); end
        n_tests++; if (o_free !== 1'b0) begin n_fail++; $display("FAIL single_early_free got %b want 0", o_free); end
        tick();
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", o_valid); end
        n_tests++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", o_count); end
        n_tests++; if (o_data !== 64'hA5A5_0000_0000_0001) begin n_fail++; $display("FAIL single_data got %h want a5a5000000000001", o_data); end
        n_tests++; if (o_free !== 1'b1) begin n_fail++; $display("FAIL single_free got %b want 1", o_free); end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        n_tests++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL single_drain_count got %0d want 0", o_count); end
        n_tests++; if (o_free !== 1'b1) begin n_fail++; $display("FAIL single_drain_free got %b want 1", o_free); end
    endtask

    // Leaves the FIFO holding 2,3,4 with o_free = 0.
    task automatic test_fill();
        int toggles;
        logic last;
        do_reset();
        toggles = 0;
        last = o_free;
        for (int k = 1; k <= 4; k++) begin
            send_token(DATA_W'(k));
            if (o_free !== last) toggles++;
            last = o_free;
        end
        n_tests++; if (toggles !== 3) begin n_fail++; $display("FAIL fill_toggles got %0d want 3", toggles); end
        n_tests++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", o_count); end
        n_tests++; if (dut.free_pending !== 1'b1) begin n_fail++; $display("FAIL fill_pending got %b want 1", dut.free_pending); end
        n_tests++; if (o_free !== 1'b1) begin n_fail++; $display("FAIL fill_free got %b want 1", o_free); end
        n_tests++; if (o_data !== 64'd1) begin n_fail++; $display("FAIL fill_head got %0d want 1", o_data); end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        n_tests++; if (o_free !== 1'b0) begin n_fail++; $display("FAIL fill_pop_free got %b want 0", o_free); end
        n_tests++; if (o_count !== 3'd3) begin n_fail++; $display("FAIL fill_pop_count got %0d want 3", o_count); end
        n_tests++; if (o_data !== 64'd2) begin n_fail++; $display("FAIL fill_pop_head got %0d want 2", o_data); end
        n_tests++; if (dut.free_pending !== 1'b0) begin n_fail++; $display("FAIL fill_pop_pending got %b want 0", dut.free_pending); end
    endtask

    // Continues from test_fill: FIFO holds 2,3,4 and o_free = 0.
    task automatic test_violation();
        send_token(64'd5);
        n_tests++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL viol_fill_count got %0d want 4", o_count); end
        n_tests++; if (o_free !== 1'b0) begin n_fail++; $display("FAIL viol_fill_free got %b want 0", o_free); end
        send_token(64'd99);
        n_tests++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL viol_overflow got %b want 1", o_overflow); end
        n_tests++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL viol_count got %0d want 4", o_count); end
        n_tests++; if (o_data !== 64'd2) begin n_fail++; $display("FAIL viol_head got %0d want 2", o_data); end
        n_tests++; if (o_free !== 1'b0) begin n_fail++; $display("FAIL viol_free got %b want 0", o_free); end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        tick();
        n_tests++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL viol_sticky got %b want 1", o_overflow); end
        n_tests++; if (o_free !== 1'b1) begin n_fail++; $display("FAIL viol_pop_free got %b want 1", o_free); end
        n_tests++; if (o_data !== 64'd3) begin n_fail++; $display("FAIL viol_pop_head got %0d want 3", o_data); end
    endtask

    // Continues with count = 3 and overflow set.
    task automatic test_reset_mid();
        n_tests++; if (o_count !== 3'd3) begin n_fail++; $display("FAIL rmid_pre_count got %0d want 3", o_count); end
        rst     = 1'b1;
        i_drive = 1'b0;
        tick();
        rst = 1'b0;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", o_valid); end
        n_tests++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL rmid_count got %0d want 0", o_count); end
        n_tests++; if (o_free !== 1'b0) begin n_fail++; $display("FAIL rmid_free got %b want 0", o_free); end
        n_tests++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_overflow got %b want 0", o_overflow); end
        send_token(64'h77);
        n_tests++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL rmid_after_count got %0d want 1", o_count); end
        n_tests++; if (o_data !== 64'h77) begin n_fail++; $display("FAIL rmid_after_data got %h want 77", o_data); end
        n_tests++; if (o_free !== 1'b1) begin n_fail++; $display("FAIL rmid_after_free got %b want 1", o_free); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        send_token(64'h10);
        send_token(64'h11);
        n_tests++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL simul_pre_count got %0d want 2", o_count); end
        n_tests++; if (o_free !== 1'b0) begin n_fail++; $display("FAIL simul_pre_free got %b want 0", o_free); end
        i_data  = 64'h12;
        i_drive = ~i_drive;
        repeat (SYNC_STAGES) tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        n_tests++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL simul_count got %0d want 2", o_count); end
        n_tests++; if (o_free !== 1'b1) begin n_fail++; $display("FAIL simul_free got %b want 1", o_free); end
        n_tests++; if (o_data !== 64'h11) begin n_fail++; $display("FAIL simul_head got %h want 11", o_data); end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        n_tests++; if (o_data !== 64'h12) begin n_fail++; $display("FAIL simul_tail got %h want 12", o_data); end
        n_tests++; if (o_free !== 1'b1) begin n_fail++; $display("FAIL simul_tail_free got %b want 1", o_free); end
    endtask

    task automatic test_wrap();
        int bad;
        int timeouts;
        do_reset();
        i_ready  = 1'b1;
        bad      = 0;
        timeouts = 0;
        for (int k = 0; k < 10; k++) begin
            i_data  = DATA_W'(k);
            i_drive = ~i_drive;
            begin
                int t;
                t = 0;
                tick();
                while (!o_valid && t < 10) begin
                    tick();
                    t++;
                end
                if (!o_valid) timeouts++;
            end
            if (o_data !== DATA_W'(k)) begin
                bad++;
                $display("FAIL wrap_data[%0d] got %0d want %0d", k, o_data, k);
            end
            tick();
        end
        i_ready = 1'b0;
        n_tests++; if (timeouts !== 0) begin n_fail++; $display("FAIL wrap_timeout got %0d want 0", timeouts); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL wrap_order got %0d wrong want 0", bad); end
        n_tests++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL wrap_count got %0d want 0", o_count); end
        n_tests++; if (dut.wr_ptr !== 2'd2) begin n_fail++; $display("FAIL wrap_wrptr got %0d want 2", dut.wr_ptr); end
        n_tests++; if (dut.rd_ptr !== 2'd2) begin n_fail++; $display("FAIL wrap_rdptr got %0d want 2", dut.rd_ptr); end
        n_tests++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_overflow got %b want 0", o_overflow); end
        n_tests++; if (o_free !== 1'b0) begin n_fail++; $display("FAIL wrap_free got %b want 0", o_free); end
    endtask

    initial begin
        rst      = 1'b1;
        i_drive  = 1'b0;
        i_ready  = 1'b0;
        i_data   = '0;
        exp_free = 1'b0;
        test_reset();
        test_single_token();
        test_fill();
        test_violation();
        test_reset_mid();
        test_simultaneous();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_req_clk_bridge.md
# cache_req_clk_bridge

Clocked receiver stage that sits directly downstream of the two-phase cache pipeline controller. It consumes the controller's transition-signalled drive/free token together with the bundled request word and converts it into a valid/ready stream for the synchronous cache logic. It buffers up to DEPTH requests and returns `o_free` to the upstream controller only when it has space to accept the next token.

## Interface
- `DATA_W`, 64: width of the bundled cache request word.
- `DEPTH`, 4: FIFO entries; a power of two, at least 2.

- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `i_drive`  in  1  upstream token, transition-signalled; each toggle is one request. Asynchronous to `clk`.
- `o_free`  out  1  acknowledge to upstream, transition-signalled; each toggle releases one token.
- `i_data`  in  DATA_W  bundled request word; stable from the `i_drive` toggle until the matching `o_free` toggle.
- `o_valid`  out  1  head entry is present.
- `i_ready`  in  1  consumer accepts the head entry; a pop occurs when `o_valid & i_ready`.
- `o_data`  out  DATA_W  head entry; holds its value while `o_valid & ~i_ready`.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy.
- `o_overflow`  out  1  sticky protocol-violation flag.

## Operation
- **Synchronizer.** `i_drive` passes through a 2-flop synchronizer into `drv_s`. A `drv_prev` register holds the previous `drv_s`.
- **Token detection.** A token is detected in any cycle where `drv_s != drv_prev`.
- **Push.** A token pushes `i_data` into the FIFO at `wr_ptr`.
  - If occupancy after the push is below DEPTH, `o_free` toggles on the same edge.
  - Otherwise `free_pending` is set and `o_free` does not toggle.
- **Pop.** A pop advances `rd_ptr`. If `free_pending` is set, `o_free` toggles on that edge and `free_pending` clears.
- **Simultaneous push and pop.** Both take effect; count is unchanged. `o_free` toggles exactly once.
- **Push while full.** A token detected while count==DEPTH (upstream violated the free rule):
  - the entry is dropped;
  - count, pointers and `o_free` are unchanged;
  - `o_overflow` sets and stays set until `rst`.
- **Pointers.** `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is kept in a separate register ranging 0..DEPTH.
- **Head data.** `o_data` is read from `mem[rd_ptr]`. `o_valid = (count != 0)`.
- **Reset.** On `rst` high at a rising edge, the following clear to 0:
  - synchronizer flops, `drv_prev`;
  - `o_free`, `free_pending`;
  - pointers and count (so `o_count` = 0, `o_valid` = 0);
  - `o_overflow`.
  
  FIFO contents are not cleared. In-flight tokens are discarded.
- **Reset requirement on upstream.** Upstream must be held in reset (`i_drive` = 0) for the same interval.
- **Reset mid-operation.** Buffered entries are lost. No `o_free` toggle is issued for them.

## Timing
- Edge E0 is the first rising edge that samples the new `i_drive` level.
  - `drv_s` updates at E1.
  - The push and any `o_free` toggle occur at E2.
  - `o_valid` is high from E2.
- Token-to-`o_free` latency is 2 clocks (3 with the macro defined below), when not full.
- When full, `o_free` toggles on the pop edge.
- Pop-to-new-space latency is 0: a pop at edge P allows a token detected at P to push.
- `o_free` and `o_valid` are direct register outputs with no combinational path from inputs.
- Sustained throughput is one token per 2–3 clocks plus the upstream round-trip time. It is bounded by the handshake, not by the FIFO.

## Configuration
- `CACHE_BRIDGE_SYNC3_EN`
  - Defined: the synchronizer is 3 flops, adding one clock to token latency. Use this for high-frequency `clk`.
  - Undefined: 2 flops.
- No other behaviour changes with this macro.

## Structure
- Shared package `cache_bridge_pkg`:
  - default `DATA_W`;
  - the synchronizer depth constant (selected by the macro);
  - pointer/count width helper functions.
- Sub-module `sync_bit`:
  - single-bit N-flop synchronizer with synchronous active-high reset to 0;
  - parameter `STAGES`;
  - instantiated once for `i_drive`.
- Top level holds the edge detector, FIFO storage, pointers, count, `free_pending` and the `o_overflow` logic.

## Test plan
- **Single token.** After reset, toggle `i_drive` 0→1 with `i_data`=64'hA5A5_0000_0000_0001 and `i_ready`=0.
  - Required: `o_valid`=1, `o_count`=1, `o_data`=64'hA5A5_0000_0000_0001, `o_free` toggled 0→1, all 2 clocks after the sampling edge.
- **Fill to full.** Send 4 tokens (data 1..4) with `i_ready`=0, each toggle waiting for `o_free`.
  - Required: `o_free` toggles 3 times, `o_count`=4, `free_pending`=1.
  - Then raise `i_ready` for one cycle: data 1 pops and `o_free` toggles on the same edge.
- **Simultaneous push and pop.** With count=2, a token push coincides with a pop.
  - Required: `o_count` stays 2 and `o_free` toggles exactly once.
- **Wrap-around.** Stream 10 tokens (data 0..9) with `i_ready`=1 throughout.
  - Required: data appears in order 0..9, pointers wrap twice, `o_overflow`=0.
- **Violation.** At count=4, force an extra `i_drive` toggle without waiting for `o_free`.
  - Required: `o_overflow`=1 (sticky), `o_count` stays 4, the head entry is unchanged.
- **Reset mid-operation.** With count=3, assert `rst` for 1 clock.
  - Required: the next cycle shows `o_valid`=0, `o_count`=0, `o_free`=0, `o_overflow`=0. A subsequent token pushes normally.
